// File: rtl/nebula_niu_axi_tgt.sv
// nebula_niu_axi_tgt: NoC-to-AXI target bridge with one transaction outstanding.
module nebula_niu_axi_tgt #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_last,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_last,
    output logic [25:0]       tx_meta,
    output logic              aw_valid,
    input  logic              aw_ready,
    output logic [31:0]       aw_addr,
    output logic [7:0]        aw_len,
    output logic              w_valid,
    input  logic              w_ready,
    output logic [DATA_W-1:0] w_data,
    output logic              w_last,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [1:0]        b_resp,
    output logic              ar_valid,
    input  logic              ar_ready,
    output logic [31:0]       ar_addr,
    output logic [7:0]        ar_len,
    input  logic              r_valid,
    output logic              r_ready,
    input  logic [DATA_W-1:0] r_data,
    input  logic [1:0]        r_resp,
    input  logic              r_last,
    output logic              err_drop
);
    typedef enum logic [3:0] {IDLE, AW, W, PAD, B, BRSP, AR, R, DRAIN} state_t;
    state_t state, state_nx;
    logic [31:0] addr;
    logic [7:0] len, beat_cnt, src_x, src_y;
    logic [3:0] id;
    logic [1:0] bresp;
    logic drain_pend, drain_set, err_q, err_nx, is_wr, is_rd, last_beat;
    assign is_wr = rx_data[47:44] == 4'd1 && !rx_last;
    assign is_rd = rx_data[47:44] == 4'd2 && rx_last;
    assign last_beat = beat_cnt == len;
    assign err_drop = err_q && !rst;
    // Outputs are forced low while rst is high, so reset silences both sides at once.
    always_comb begin
        state_nx = state;
        err_nx = 1'b0;
        drain_set = 1'b0;
        rx_ready = 1'b0;
        tx_valid = 1'b0;
        tx_data = '0;
        tx_last = 1'b0;
        tx_meta = '0;
        aw_valid = 1'b0;
        aw_addr = '0;
        aw_len = '0;
        w_valid = 1'b0;
        w_data = '0;
        w_last = 1'b0;
        b_ready = 1'b0;
        ar_valid = 1'b0;
        ar_addr = '0;
        ar_len = '0;
        r_ready = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    rx_ready = 1'b1;
                    if (rx_valid) begin
                        state_nx = is_wr ? AW : is_rd ? AR : rx_last ? IDLE : DRAIN;
                        err_nx = !is_wr && !is_rd;
                    end
                end
                AW: begin
                    aw_valid = 1'b1;
                    aw_addr = addr;
                    aw_len = len;
                    state_nx = aw_ready ? W : AW;
                end
                W: begin
                    w_valid = rx_valid;
                    rx_ready = w_ready;
                    w_data = rx_data;
                    w_last = last_beat;
                    if (rx_valid && w_ready) begin
                        state_nx = last_beat ? B : rx_last ? PAD : W;
                        drain_set = last_beat && !rx_last;
                        err_nx = last_beat ? !rx_last : rx_last;
                    end
                end
                PAD: begin
                    w_valid = 1'b1;
                    w_last = last_beat;
                    state_nx = w_ready && last_beat ? B : PAD;
                end
                B: begin
                    b_ready = 1'b1;
                    state_nx = b_valid ? BRSP : B;
                end
                BRSP: begin
                    tx_valid = 1'b1;
                    tx_last = 1'b1;
                    tx_meta = {src_y, src_x, 4'd3, id, bresp};
                    state_nx = !tx_ready ? BRSP : drain_pend ? DRAIN : IDLE;
                end
                AR: begin
                    ar_valid = 1'b1;
                    ar_addr = addr;
                    ar_len = len;
                    state_nx = ar_ready ? R : AR;
                end
                R: begin
                    tx_valid = r_valid;
                    r_ready = tx_ready;
                    tx_data = r_data;
                    tx_last = r_last;
                    tx_meta = {src_y, src_x, 4'd4, id, r_resp};
                    state_nx = r_valid && tx_ready && r_last ? IDLE : R;
                end
                DRAIN: begin
                    rx_ready = 1'b1;
                    state_nx = rx_valid && rx_last ? IDLE : DRAIN;
                end
                default: state_nx = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            beat_cnt <= '0;
            drain_pend <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state <= state_nx;
            err_q <= err_nx;
            if (state == IDLE && rx_valid) begin
                addr <= rx_data[31:0];
                len <= rx_data[39:32];
                id <= rx_data[43:40];
                src_x <= rx_data[55:48];
                src_y <= rx_data[63:56];
            end
            if (state == AW)
                beat_cnt <= '0;
            else if (w_valid && w_ready)
                beat_cnt <= beat_cnt + 8'd1;
            if (drain_set)
                drain_pend <= 1'b1;
            else if (state == BRSP && tx_ready)
                drain_pend <= 1'b0;
            if (state == B && b_valid)
                bresp <= b_resp;
        end
    end
endmodule
